// File: rtl/vecmac_pkg.sv
// Shared definitions for the vector-MAC sequencer slice.
//   state_e    : sequencer FSM states
//   LANES      : byte lanes per operand beat
//   BYTE_W     : lane width
//   PROD_W     : u8 x u8 product width
//   TREE_SUM_W : width of the 4-input adder-tree result
package vecmac_pkg;

  localparam int LANES      = 4;
  localparam int BYTE_W     = 8;
  localparam int PROD_W     = 16;
  localparam int TREE_SUM_W = 18;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FEED  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_FLUSH = 3'd4
  } state_e;

endpackage

// File: rtl/vecmac_prod4.sv
// Registered 4-lane unsigned u8 x u8 multiplier.
//   clk, rst_n : clock, async active-low reset
//   i_load     : capture products of i_a/i_b this edge
//   i_a, i_b   : LANES x u8 operands, lane l = [8l+7:8l]
//   o_valid    : high for exactly the cycle after each i_load
//   o_prod     : registered products, held between loads
module vecmac_prod4
  import vecmac_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_load,
  input  logic [LANES*BYTE_W-1:0]        i_a,
  input  logic [LANES*BYTE_W-1:0]        i_b,
  output logic                           o_valid,
  output logic [LANES-1:0][PROD_W-1:0]   o_prod
);

  logic                         r_valid;
  logic [LANES-1:0][PROD_W-1:0] r_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_prod  <= '0;
    end else begin
      r_valid <= i_load;
      if (i_load) begin
        for (int l = 0; l < LANES; l++) begin
          r_prod[l] <= PROD_W'(i_a[BYTE_W*l +: BYTE_W]) * PROD_W'(i_b[BYTE_W*l +: BYTE_W]);
        end
      end
    end
  end

  assign o_valid = r_valid;
  assign o_prod  = r_prod;

endmodule

// File: rtl/vecmac_seq_ctrl.sv
// Sequencer for one unsigned int8 dot product over LEN 4-element chunks.
// Streams operand beats into registered multipliers, feeds the external
// 2-stage adder tree and accumulates its sums into a single result.
//   clk, rst_n                : clock, async active-low reset
//   i_cmd_valid/o_cmd_ready   : command handshake, i_cmd_len = chunk count (0 legal)
//   i_op_valid/o_op_ready     : operand beat handshake, i_op_a/i_op_b = 4 x u8
//   i_abort                   : cancel current command (FEED/DRAIN only)
//   o_tree_in_valid, o_tree_p*: product beat to adder tree
//   i_tree_out_valid, i_tree_sum : adder tree result
//   o_res_valid/i_res_ready, o_res_data : result handshake
//   o_err_stray               : sticky, tree result seen with nothing outstanding
module vecmac_seq_ctrl
  import vecmac_pkg::*;
#(
  parameter int LEN_W    = 8,
  parameter int TREE_LAT = 2,
  parameter int ACC_W    = TREE_SUM_W + LEN_W
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic [LEN_W-1:0]        i_cmd_len,
  input  logic                    i_op_valid,
  output logic                    o_op_ready,
  input  logic [31:0]             i_op_a,
  input  logic [31:0]             i_op_b,
  input  logic                    i_abort,
  output logic                    o_tree_in_valid,
  output logic [PROD_W-1:0]       o_tree_p0,
  output logic [PROD_W-1:0]       o_tree_p1,
  output logic [PROD_W-1:0]       o_tree_p2,
  output logic [PROD_W-1:0]       o_tree_p3,
  input  logic                    i_tree_out_valid,
  input  logic [TREE_SUM_W-1:0]   i_tree_sum,
  output logic                    o_res_valid,
  input  logic                    i_res_ready,
  output logic [ACC_W-1:0]        o_res_data,
  output logic                    o_err_stray
);

  // At most TREE_LAT+1 beats are ever between accept and return.
  localparam int OUT_W = $clog2(TREE_LAT + 2);

  state_e                  r_state, w_next;
  logic [LEN_W-1:0]        r_len;
  logic [LEN_W-1:0]        r_issued;
  logic [OUT_W-1:0]        r_out;
  logic [OUT_W-1:0]        w_out_nxt;
  logic [ACC_W-1:0]        r_acc;
  logic                    r_err_stray;

  logic                    w_cmd_acc;
  logic                    w_op_acc;
  logic                    w_ret;
  logic                    w_stray;
  logic                    w_last_beat;
  logic [LANES-1:0][PROD_W-1:0] w_prod;

  // Abort wins over a simultaneous beat, so it masks op_ready directly.
  assign o_op_ready  = (r_state == ST_FEED) && !i_abort;
  assign w_cmd_acc   = o_cmd_ready && i_cmd_valid;
  assign w_op_acc    = o_op_ready && i_op_valid;
  assign w_ret       = i_tree_out_valid && (r_out != '0);
  assign w_stray     = i_tree_out_valid && (r_out == '0);
  assign w_last_beat = w_op_acc && ((r_issued + LEN_W'(1)) == r_len);

  // Outstanding is counted from beat accept, so a return can never race it.
  always_comb begin
    w_out_nxt = r_out;
    case ({w_op_acc, w_ret})
      2'b10:   w_out_nxt = r_out + OUT_W'(1);
      2'b01:   w_out_nxt = r_out - OUT_W'(1);
      default: w_out_nxt = r_out;
    endcase
  end

  always_comb begin
    w_next      = r_state;
    o_cmd_ready = 1'b0;
    o_res_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) w_next = (i_cmd_len == '0) ? ST_DONE : ST_FEED;
      end
      ST_FEED: begin
        if (i_abort)          w_next = ST_FLUSH;
        else if (w_last_beat) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (i_abort)                        w_next = ST_FLUSH;
        else if (w_ret && (r_out == OUT_W'(1))) w_next = ST_DONE;
      end
      ST_DONE: begin
        o_res_valid = 1'b1;
        if (i_res_ready) w_next = ST_IDLE;
      end
      ST_FLUSH: begin
        if (w_out_nxt == '0) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len       <= '0;
      r_issued    <= '0;
      r_out       <= '0;
      r_acc       <= '0;
      r_err_stray <= 1'b0;
    end else begin
      r_out <= w_out_nxt;
      if (w_cmd_acc) begin
        r_len    <= i_cmd_len;
        r_issued <= '0;
        r_acc    <= '0;
      end else begin
        if (w_op_acc) r_issued <= r_issued + LEN_W'(1);
        // Returns during FLUSH only retire outstanding work; acc is dropped.
        if (w_ret && (r_state == ST_FEED || r_state == ST_DRAIN))
          r_acc <= r_acc + ACC_W'(i_tree_sum);
      end
      // A stray in the accepting cycle still latches.
      if (w_stray)        r_err_stray <= 1'b1;
      else if (w_cmd_acc) r_err_stray <= 1'b0;
    end
  end

  vecmac_prod4 u_prod (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_op_acc),
    .i_a     (i_op_a),
    .i_b     (i_op_b),
    .o_valid (o_tree_in_valid),
    .o_prod  (w_prod)
  );

  assign o_tree_p0   = w_prod[0];
  assign o_tree_p1   = w_prod[1];
  assign o_tree_p2   = w_prod[2];
  assign o_tree_p3   = w_prod[3];
  assign o_res_data  = r_acc;
  assign o_err_stray = r_err_stray;

endmodule

// File: tb/tb_vecmac_seq_ctrl.sv
// Directed bench for vecmac_seq_ctrl with a behavioural 2-stage adder tree.
module tb_vecmac_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_len = '0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        abort = 1'b0;
  logic        tree_in_valid;
  logic [15:0] p0, p1, p2, p3;
  logic        tree_out_valid;
  logic [17:0] tree_sum;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [25:0] res_data;
  logic        err_stray;

  // Adder tree model plus a stray-injection port.
  logic        s1_v, s2_v;
  logic [17:0] s1_sum, s2_sum;
  logic        inj_v = 1'b0;
  logic [17:0] inj_sum = '0;

  int checks = 0;
  int errors = 0;
  int tiv_cnt = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0; s2_v <= 1'b0; s1_sum <= '0; s2_sum <= '0;
    end else begin
      s1_v   <= tree_in_valid;
      s1_sum <= 18'(p0) + 18'(p1) + 18'(p2) + 18'(p3);
      s2_v   <= s1_v;
      s2_sum <= s1_sum;
    end
  end

  assign tree_out_valid = s2_v | inj_v;
  assign tree_sum       = inj_v ? inj_sum : s2_sum;

  always @(posedge clk) if (rst_n && tree_in_valid) tiv_cnt++;

  vecmac_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_len(cmd_len),
    .i_op_valid(op_valid), .o_op_ready(op_ready), .i_op_a(op_a), .i_op_b(op_b),
    .i_abort(abort),
    .o_tree_in_valid(tree_in_valid),
    .o_tree_p0(p0), .o_tree_p1(p1), .o_tree_p2(p2), .o_tree_p3(p3),
    .i_tree_out_valid(tree_out_valid), .i_tree_sum(tree_sum),
    .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_data(res_data),
    .o_err_stray(err_stray)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Ticks until res_valid; returns cycles taken (bounded).
  task automatic wait_res(output int n);
    n = 0;
    while (!res_valid && n < 2000) begin tick(); n++; end
  endtask

  task automatic send_cmd(input logic [7:0] len);
    cmd_valid = 1'b1; cmd_len = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int n, base, drop, unstable, early;
    logic [25:0] held;

    // Reset state
    #2;
    chk("rst_tiv", tree_in_valid, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_err", err_stray, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_p0", p0, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_op_ready", op_ready, 0);
    tick(); rst_n = 1'b1; tick();

    // len=1, all lanes 255*255
    base = tiv_cnt;
    send_cmd(8'd1);
    op_valid = 1'b1; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; #1;
    chk("t1_op_ready", op_ready, 1);
    tick(); op_valid = 1'b0;
    wait_res(n);
    chk("t1_latency", n, 3);
    chk("t1_res", res_data, 260100);
    chk("t1_p3", p3, 16'hFE01);
    chk("t1_tiv_pulses", tiv_cnt - base, 1);
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    chk("t1_res_clr", res_valid, 0);

    // len=255, back-to-back beats
    base = tiv_cnt; drop = 0;
    send_cmd(8'd255);
    op_valid = 1'b1;
    for (int i = 0; i < 255; i++) begin
      if (!op_ready) drop++;
      tick();
    end
    op_valid = 1'b0;
    chk("t2_op_ready_drops", drop, 0);
    chk("t2_drain_op_ready", op_ready, 0);
    wait_res(n);
    chk("t2_latency", n, 3);
    chk("t2_res", res_data, 66325500);
    chk("t2_tiv_pulses", tiv_cnt - base, 255);
    res_ready = 1'b1; tick(); res_ready = 1'b0;

    // len=0, plus abort ignored in DONE
    base = tiv_cnt;
    send_cmd(8'd0);
    chk("t3_res_valid", res_valid, 1);
    chk("t3_res", res_data, 0);
    chk("t3_cmd_ready_done", cmd_ready, 0);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t3_abort_ignored", res_valid, 1);
    tick();
    chk("t3_tiv_pulses", tiv_cnt - base, 0);
    res_ready = 1'b1; tick(); res_ready = 1'b0;

    // len=4 with gaps, result held while res_ready low
    send_cmd(8'd4);
    op_valid = 1'b1; op_a = 32'h0102_0304; op_b = 32'h0506_0708; tick();
    op_valid = 1'b0; tick();
    op_valid = 1'b1; op_a = 32'hFF00_0000; op_b = 32'hFF00_0000; tick();
    op_valid = 1'b0; tick(); tick();
    op_valid = 1'b1; op_a = 32'h1010_1010; op_b = 32'h0202_0202; tick();
    op_a = 32'h0000_0080; op_b = 32'h0000_0003; tick();
    op_valid = 1'b0;
    wait_res(n);
    chk("t4_latency", n, 3);
    chk("t4_res", res_data, 65607);
    held = res_data; unstable = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!res_valid || res_data !== held) unstable++;
    end
    chk("t4_hold", unstable, 0);
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    chk("t4_res_clr", res_valid, 0);

    // abort after 2 of 4 beats, then len=1 of 1*1 lanes
    base = tiv_cnt; early = 0;
    send_cmd(8'd4);
    op_valid = 1'b1; op_a = 32'h0101_0101; op_b = 32'h0101_0101; tick(); tick();
    abort = 1'b1; #1;
    chk("t5_abort_masks_beat", op_ready, 0);
    tick(); abort = 1'b0; op_valid = 1'b0;
    n = 0;
    while (!cmd_ready && n < 50) begin
      if (res_valid) early++;
      tick(); n++;
    end
    chk("t5_flush_ends", cmd_ready, 1);
    chk("t5_no_result", early, 0);
    chk("t5_tiv_pulses", tiv_cnt - base, 2);
    send_cmd(8'd1);
    op_valid = 1'b1; tick(); op_valid = 1'b0;
    wait_res(n);
    chk("t5_res", res_data, 4);
    chk("t5_err", err_stray, 0);
    res_ready = 1'b1; tick(); res_ready = 1'b0;

    // stray return in IDLE
    inj_v = 1'b1; inj_sum = 18'd5; tick(); inj_v = 1'b0;
    chk("t6_err_set", err_stray, 1);
    tick(); tick();
    chk("t6_err_held", err_stray, 1);
    chk("t6_acc_unaffected", res_data, 4);
    send_cmd(8'd0);
    chk("t6_err_clr", err_stray, 0);
    chk("t6_res", res_data, 0);
    res_ready = 1'b1; tick(); res_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
